// File: rtl/pe_array_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pe_array_ctrl_pkg
// Shared definitions for the pe_array column sequencer:
//   - FSM state encoding (3-bit constants)
//   - pe_array mode encodings
//   - default PE output latency and the drain-length formula
// No ports (package).
// -----------------------------------------------------------------------------
package pe_array_ctrl_pkg;

`ifndef OUTPUT_LAT
`define OUTPUT_LAT 2
`endif

    // PE psum latency; the build may override it so it matches pe_array.
    localparam int OUTPUT_LAT_DEF = `OUTPUT_LAT;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [1:0] MODE_CONV    = 2'b00;
    localparam logic [1:0] MODE_MAXPOOL = 2'b01;

    // Cycles from the we pulse until all 8 lanes of the skewed output word
    // are valid: 8 cycles of lane skew + PE latency + output register.
    function automatic int drain_cycles(input int lat);
        return lat + 9;
    endfunction

endpackage

// File: rtl/pe_array_ctrl_addr_gen.sv
// -----------------------------------------------------------------------------
// pe_array_ctrl_addr_gen
// Address pointers and operand/tile counters for the column sequencer.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   load_i                   run accepted: load bases, clear k/t
//   step_i                   one operand read this cycle: advance A/B, k++
//   next_tile_i              output accepted, more tiles: rewind A, t++, out++
//   a_base_i/b_base_i/out_base_i  base addresses (used on load_i)
//   k_o, t_o                 operand index within tile, tile index
//   a_addr_o/b_addr_o/out_addr_o  current pointers
// -----------------------------------------------------------------------------
module pe_array_ctrl_addr_gen
    import pe_array_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic                  next_tile_i,
    input  logic [ADDR_WIDTH-1:0] a_base_i,
    input  logic [ADDR_WIDTH-1:0] b_base_i,
    input  logic [ADDR_WIDTH-1:0] out_base_i,
    output logic [LEN_WIDTH-1:0]  k_o,
    output logic [LEN_WIDTH-1:0]  t_o,
    output logic [ADDR_WIDTH-1:0] a_addr_o,
    output logic [ADDR_WIDTH-1:0] b_addr_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o
);

    localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]  L_ONE = 1;

    logic [ADDR_WIDTH-1:0] a_base_q, a_base_d;
    logic [ADDR_WIDTH-1:0] a_ptr_q, a_ptr_d;
    logic [ADDR_WIDTH-1:0] b_ptr_q, b_ptr_d;
    logic [ADDR_WIDTH-1:0] out_ptr_q, out_ptr_d;
    logic [LEN_WIDTH-1:0]  k_q, k_d;
    logic [LEN_WIDTH-1:0]  t_q, t_d;

    // B is never rewound: running straight on past the last operand of a
    // tile lands exactly on b_base + (t+1)*k_len, so no multiply is needed.
    always_comb begin
        a_base_d  = a_base_q;
        a_ptr_d   = a_ptr_q;
        b_ptr_d   = b_ptr_q;
        out_ptr_d = out_ptr_q;
        k_d       = k_q;
        t_d       = t_q;
        if (load_i) begin
            a_base_d  = a_base_i;
            a_ptr_d   = a_base_i;
            b_ptr_d   = b_base_i;
            out_ptr_d = out_base_i;
            k_d       = '0;
            t_d       = '0;
        end else begin
            if (step_i) begin
                a_ptr_d = a_ptr_q + A_ONE;
                b_ptr_d = b_ptr_q + A_ONE;
                k_d     = k_q + L_ONE;
            end
            if (next_tile_i) begin
                a_ptr_d   = a_base_q;
                out_ptr_d = out_ptr_q + A_ONE;
                k_d       = '0;
                t_d       = t_q + L_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_base_q  <= '0;
            a_ptr_q   <= '0;
            b_ptr_q   <= '0;
            out_ptr_q <= '0;
            k_q       <= '0;
            t_q       <= '0;
        end else begin
            a_base_q  <= a_base_d;
            a_ptr_q   <= a_ptr_d;
            b_ptr_q   <= b_ptr_d;
            out_ptr_q <= out_ptr_d;
            k_q       <= k_d;
            t_q       <= t_d;
        end
    end

    assign k_o        = k_q;
    assign t_o        = t_q;
    assign a_addr_o   = a_ptr_q;
    assign b_addr_o   = b_ptr_q;
    assign out_addr_o = out_ptr_q;

endmodule

// File: rtl/pe_array_ctrl.sv
// -----------------------------------------------------------------------------
// pe_array_ctrl
// Sequencer for one 8-PE pe_array column. Per tile it streams k_len operand
// pairs from the A/B buffers (clr with the first, we with the last), waits
// DRAIN_CYCLES for the skewed output word, then writes it to the output
// buffer under a ready handshake. Repeats n_tiles times, then pulses done_o.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i                      start pulse (IDLE only)
//   mode_i, k_len_i, n_tiles_i   run config, latched at start
//   a_base_i/b_base_i/out_base_i base addresses, latched at start
//   busy_o, done_o               status
//   a_rd_o/b_rd_o, a_addr_o/b_addr_o   operand buffer reads
//   pe_clr_o, pe_we_o, pe_mode_o       pe_array control (aligned to read data)
//   out_we_o, out_addr_o, out_ready_i  output buffer write handshake
// Optional (macro PE_ARRAY_CTRL_PERF_EN):
//   perf_busy_cycles_o, perf_stall_cycles_o  saturating 32-bit counters
// -----------------------------------------------------------------------------
module pe_array_ctrl
    import pe_array_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int LEN_WIDTH    = 8,
    parameter int OUTPUT_LAT   = OUTPUT_LAT_DEF,
    parameter int DRAIN_CYCLES = drain_cycles(OUTPUT_LAT)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [LEN_WIDTH-1:0]  k_len_i,
    input  logic [LEN_WIDTH-1:0]  n_tiles_i,
    input  logic [ADDR_WIDTH-1:0] a_base_i,
    input  logic [ADDR_WIDTH-1:0] b_base_i,
    input  logic [ADDR_WIDTH-1:0] out_base_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  a_rd_o,
    output logic                  b_rd_o,
    output logic [ADDR_WIDTH-1:0] a_addr_o,
    output logic [ADDR_WIDTH-1:0] b_addr_o,
    output logic                  pe_clr_o,
    output logic                  pe_we_o,
    output logic [1:0]            pe_mode_o,
    output logic                  out_we_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    input  logic                  out_ready_i
`ifdef PE_ARRAY_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_busy_cycles_o,
    output logic [31:0]           perf_stall_cycles_o
`endif
);

    localparam int                DRW        = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRW-1:0]    DRAIN_LAST = DRW'(DRAIN_CYCLES - 1);
    localparam logic [DRW-1:0]    DR_ONE     = 1;
    localparam logic [LEN_WIDTH-1:0] L_ONE   = 1;

    logic [2:0]           state_q, state_d;
    logic [DRW-1:0]       drain_q, drain_d;
    logic [1:0]           mode_q;
    logic [LEN_WIDTH-1:0] k_len_q;
    logic [LEN_WIDTH-1:0] n_tiles_q;
    logic                 pe_clr_q;
    logic                 pe_we_q;

    logic [LEN_WIDTH-1:0] k;
    logic [LEN_WIDTH-1:0] t;
    logic                 start_acc;
    logic                 step;
    logic                 k_last;
    logic                 t_last;
    logic                 accept;

    assign start_acc = (state_q == ST_IDLE) && start_i;
    assign step      = (state_q == ST_READ);
    assign k_last    = (k == k_len_q - L_ONE);
    assign t_last    = (t == n_tiles_q - L_ONE);
    assign accept    = (state_q == ST_WRITE) && out_ready_i;

    pe_array_ctrl_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_addr_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (start_acc),
        .step_i     (step),
        .next_tile_i(accept && !t_last),
        .a_base_i   (a_base_i),
        .b_base_i   (b_base_i),
        .out_base_i (out_base_i),
        .k_o        (k),
        .t_o        (t),
        .a_addr_o   (a_addr_o),
        .b_addr_o   (b_addr_o),
        .out_addr_o (out_addr_o)
    );

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    // Empty runs skip straight to the done pulse.
                    if (k_len_i == '0 || n_tiles_i == '0) state_d = ST_DONE;
                    else                                  state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (k_last) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            // First DRAIN cycle coincides with the pe_we pulse.
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = ST_WRITE;
                else                       drain_d = drain_q + DR_ONE;
            end
            ST_WRITE: begin
                if (out_ready_i) state_d = t_last ? ST_DONE : ST_READ;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            drain_q   <= '0;
            mode_q    <= MODE_CONV;
            k_len_q   <= '0;
            n_tiles_q <= '0;
            pe_clr_q  <= 1'b0;
            pe_we_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            // Delayed one cycle so they line up with the buffer read data.
            pe_clr_q <= step && (k == '0);
            pe_we_q  <= step && k_last;
            if (start_acc) begin
                mode_q    <= mode_i;
                k_len_q   <= k_len_i;
                n_tiles_q <= n_tiles_i;
            end
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = (state_q == ST_DONE);
    assign a_rd_o    = step;
    assign b_rd_o    = step;
    assign pe_clr_o  = pe_clr_q;
    assign pe_we_o   = pe_we_q;
    assign pe_mode_o = mode_q;
    assign out_we_o  = (state_q == ST_WRITE);

`ifdef PE_ARRAY_CTRL_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if (start_acc) begin
            perf_busy_d  = '0;
            perf_stall_d = '0;
        end else begin
            if (busy_o && perf_busy_q != '1)
                perf_busy_d = perf_busy_q + 32'd1;
            if (out_we_o && !out_ready_i && perf_stall_q != '1)
                perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_busy_cycles_o  = perf_busy_q;
    assign perf_stall_cycles_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_pe_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pe_array_ctrl
// Randomized bench for pe_array_ctrl. A negedge monitor records every read,
// clr/we pulse, output write and done pulse; after each run the recorded
// trace is compared with the schedule computed from the run parameters.
// -----------------------------------------------------------------------------
module tb_pe_array_ctrl;
    import pe_array_ctrl_pkg::*;

    localparam int D    = OUTPUT_LAT_DEF + 9;
    localparam int MASK = 1023;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [1:0] mode_i = 2'b00;
    logic [7:0] k_len_i = '0;
    logic [7:0] n_tiles_i = '0;
    logic [9:0] a_base_i = '0, b_base_i = '0, out_base_i = '0;
    logic       busy_o, done_o, a_rd_o, b_rd_o, pe_clr_o, pe_we_o, out_we_o;
    logic [9:0] a_addr_o, b_addr_o, out_addr_o;
    logic [1:0] pe_mode_o;
    logic       out_ready_i = 1'b0;
`ifdef PE_ARRAY_CTRL_PERF_EN
    logic [31:0] perf_busy_cycles_o, perf_stall_cycles_o;
`endif

    pe_array_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
        .k_len_i(k_len_i), .n_tiles_i(n_tiles_i),
        .a_base_i(a_base_i), .b_base_i(b_base_i), .out_base_i(out_base_i),
        .busy_o(busy_o), .done_o(done_o), .a_rd_o(a_rd_o), .b_rd_o(b_rd_o),
        .a_addr_o(a_addr_o), .b_addr_o(b_addr_o),
        .pe_clr_o(pe_clr_o), .pe_we_o(pe_we_o), .pe_mode_o(pe_mode_o),
        .out_we_o(out_we_o), .out_addr_o(out_addr_o), .out_ready_i(out_ready_i)
`ifdef PE_ARRAY_CTRL_PERF_EN
        , .perf_busy_cycles_o(perf_busy_cycles_o),
        .perf_stall_cycles_o(perf_stall_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Monitor state
    int rd_a[$], rd_b[$], rd_c[$], clr_c[$], we_c[$], done_c[$], done_m[$];
    int wr_first[$], acc_c[$], acc_a[$];
    int rd_split, wr_run, wr_addr0, wr_unstable, busy_n, busy_first, busy_last;
    int stall_n[16];
    bit jam_en = 0;

    task automatic clear_mon();
        rd_a.delete(); rd_b.delete(); rd_c.delete(); clr_c.delete(); we_c.delete();
        done_c.delete(); done_m.delete(); wr_first.delete(); acc_c.delete(); acc_a.delete();
        rd_split = 0; wr_run = 0; wr_addr0 = 0; wr_unstable = 0;
        busy_n = 0; busy_first = -1; busy_last = -1;
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial forever begin
        @(negedge clk_i);
        if (a_rd_o) begin
            rd_a.push_back(int'(a_addr_o)); rd_b.push_back(int'(b_addr_o)); rd_c.push_back(cyc);
        end
        if (a_rd_o != b_rd_o) rd_split++;
        if (pe_clr_o) clr_c.push_back(cyc);
        if (pe_we_o)  we_c.push_back(cyc);
        if (done_o) begin done_c.push_back(cyc); done_m.push_back(int'(pe_mode_o)); end
        if (busy_o) begin
            busy_n++;
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
        end
        if (out_we_o) begin
            if (wr_run == 0) begin wr_first.push_back(cyc); wr_addr0 = int'(out_addr_o); end
            else if (int'(out_addr_o) != wr_addr0) wr_unstable++;
            out_ready_i = (wr_run >= stall_n[(acc_c.size() > 15) ? 15 : acc_c.size()]);
            if (out_ready_i) begin
                acc_c.push_back(cyc); acc_a.push_back(int'(out_addr_o)); wr_run = 0;
            end else wr_run++;
        end else begin
            out_ready_i = 1'($urandom_range(0, 1));
        end
        // While running, scramble start and config: all must be ignored.
        if (jam_en) begin
            if (busy_o && !done_o) begin
                start_i   = 1'($urandom_range(0, 1));
                mode_i    = 2'($urandom);
                k_len_i   = 8'($urandom);
                n_tiles_i = 8'($urandom);
                a_base_i  = 10'($urandom); b_base_i = 10'($urandom); out_base_i = 10'($urandom);
            end else begin
                start_i = 1'b0;
            end
        end
    end

    task automatic run(input int kl, input int nt, input int ab, input int bb,
                       input int ob, input int md);
        int s, ts, we, acc, exp_done, budget, ssum;
        clear_mon();
        jam_en = 0;
        @(posedge clk_i); #1;
        k_len_i = 8'(kl); n_tiles_i = 8'(nt); mode_i = 2'(md);
        a_base_i = 10'(ab); b_base_i = 10'(bb); out_base_i = 10'(ob);
        start_i = 1'b1;
        s = cyc;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        jam_en = 1;
        budget = 40 + nt * (kl + D + 24);
        while (done_c.size() == 0 && cyc < s + budget) @(posedge clk_i);
        repeat (4) @(posedge clk_i);
        #1;
        jam_en = 0;
        start_i = 1'b0;

        check_val("done_count", done_c.size(), 1);
        check_val("rd_split", rd_split, 0);
        ssum = 0;
        if (kl == 0 || nt == 0) begin
            check_val("empty_reads", rd_c.size(), 0);
            check_val("empty_writes", wr_first.size(), 0);
            check_val("empty_clr_we", clr_c.size() + we_c.size(), 0);
            exp_done = s + 1;
        end else begin
            check_val("read_count", rd_c.size(), kl * nt);
            check_val("clr_count", clr_c.size(), nt);
            check_val("we_count", we_c.size(), nt);
            check_val("write_count", acc_c.size(), nt);
            ts = s + 1;
            acc = 0;
            for (int t = 0; t < nt; t++) begin
                for (int k = 0; k < kl; k++) begin
                    int i = t * kl + k;
                    check_val($sformatf("a_addr t%0d k%0d", t, k), qget(rd_a, i), (ab + k) & MASK);
                    check_val($sformatf("b_addr t%0d k%0d", t, k), qget(rd_b, i), (bb + t * kl + k) & MASK);
                    check_val($sformatf("rd_cyc t%0d k%0d", t, k), qget(rd_c, i), ts + k);
                end
                we = ts + kl;
                check_val($sformatf("clr_cyc t%0d", t), qget(clr_c, t), ts + 1);
                check_val($sformatf("we_cyc t%0d", t), qget(we_c, t), we);
                check_val($sformatf("outwe_cyc t%0d", t), qget(wr_first, t), we + D);
                acc = we + D + stall_n[t];
                ssum += stall_n[t];
                check_val($sformatf("accept_cyc t%0d", t), qget(acc_c, t), acc);
                check_val($sformatf("out_addr t%0d", t), qget(acc_a, t), (ob + t) & MASK);
                ts = acc + 1;
            end
            exp_done = acc + 1;
            check_val("out_addr_stable", wr_unstable, 0);
        end
        check_val("done_cyc", qget(done_c, 0), exp_done);
        check_val("done_mode", qget(done_m, 0), md);
        check_val("busy_first", busy_first, s + 1);
        check_val("busy_last", busy_last, exp_done);
        check_val("busy_cycles", busy_n, exp_done - s);
`ifdef PE_ARRAY_CTRL_PERF_EN
        check_val("perf_busy", perf_busy_cycles_o, exp_done - s);
        check_val("perf_stall", perf_stall_cycles_o, ssum);
`endif
    endtask

    function automatic logic [38:0] out_vec();
        return {busy_o, done_o, a_rd_o, b_rd_o, a_addr_o, b_addr_o, pe_clr_o,
                pe_we_o, pe_mode_o, out_we_o, out_addr_o};
    endfunction

    task automatic zero_stalls();
        for (int i = 0; i < 16; i++) stall_n[i] = 0;
    endtask

    initial begin
        zero_stalls();
        clear_mon();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_val("reset_outputs", out_vec(), 0);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_val("post_reset_outputs", out_vec(), 0);

        run(4, 1, 'h10, 'h20, 'h30, 0);
        run(3, 3, 'h40, 'h80, 'h100, 1);
        stall_n[0] = 5;
        run(2, 2, 'h5, 'h7, 'h9, 0);
        zero_stalls();
        run(1, 2, 'h11, 'h22, 'h33, 1);
        run(0, 3, 'h1, 'h2, 'h3, 0);
        run(5, 0, 'h1, 'h2, 'h3, 1);
        run(3, 2, 'h3FE, 'h3FD, 'h3FF, 0);

        // Reset while reading: everything drops, no done and no write follows.
        clear_mon();
        @(posedge clk_i); #1;
        k_len_i = 8'd8; n_tiles_i = 8'd2; a_base_i = 10'h50; b_base_i = 10'h60;
        out_base_i = 10'h70; mode_i = 2'b01; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_val("midrun_reading", int'(a_rd_o), 1);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check_val("midrun_reset_outputs", out_vec(), 0);
        rst_i = 1'b0;
        clear_mon();
        repeat (30) @(posedge clk_i);
        check_val("after_reset_quiet", rd_c.size() + acc_c.size() + done_c.size() + busy_n, 0);
        run(4, 2, 'h50, 'h60, 'h70, 1);

        // Three stall cycles on a single tile.
        stall_n[0] = 3;
        run(4, 1, 'h10, 'h20, 'h30, 0);
        zero_stalls();

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) stall_n[i] = $urandom_range(0, 3);
            run($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 1023),
                $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
